// File: rtl/add_round_key_stream_if.sv
// Handshake bundle for the AddRoundKey stream stage: text, key and result streams plus status.
interface add_round_key_stream_if #(
  parameter int NBYTES = 16,
  parameter int BYTEW  = 8,
  parameter int CNT_W  = 8
);
  logic [NBYTES*BYTEW-1:0] text_in, key_in, data_out;
  logic                    text_valid, text_ready;
  logic                    key_valid, key_ready;
  logic                    out_valid, out_ready;
  logic                    key_loaded;
  logic [CNT_W-1:0]        blk_cnt;

  modport master (
    output text_in, text_valid, key_in, key_valid, out_ready,
    input  text_ready, key_ready, data_out, out_valid, key_loaded, blk_cnt
  );
  modport slave (
    input  text_in, text_valid, key_in, key_valid, out_ready,
    output text_ready, key_ready, data_out, out_valid, key_loaded, blk_cnt
  );
endinterface

// File: rtl/add_round_key_stream.sv
// AddRoundKey stage: per-byte XOR of a state block with the held round key, results
// queued in a 2-entry output buffer whose head drives data_out.
module ark_lane #(
  parameter int BYTEW = 8
) (
  input  logic [BYTEW-1:0] txt_i,
  input  logic [BYTEW-1:0] key_i,
  output logic [BYTEW-1:0] res_o
);
  assign res_o = txt_i ^ key_i;
endmodule

module add_round_key_stream #(
  parameter int NBYTES   = 16,
  parameter int BYTEW    = 8,
  parameter int KEY_HOLD = 1,
  parameter int CNT_W    = 8
) (
  input logic                   sys_clk,
  input logic                   sys_rst_n,
  add_round_key_stream_if.slave bus
);
  logic [NBYTES-1:0][BYTEW-1:0] key_q, key_d;
  logic [NBYTES-1:0][BYTEW-1:0] head_q, head_d, tail_q, tail_d;
  logic [NBYTES-1:0][BYTEW-1:0] txt, xored;
  logic                         key_loaded_q, key_loaded_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic [CNT_W-1:0]             blk_cnt_q, blk_cnt_d;
  logic                         text_fire, key_fire, pop;

  assign txt = bus.text_in;

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    ark_lane #(.BYTEW(BYTEW)) u_lane (
      .txt_i (txt[g]),
      .key_i (key_q[g]),
      .res_o (xored[g])
    );
  end

  // text_ready depends only on registered state, so no path from out_ready
  assign bus.text_ready = key_loaded_q && (cnt_q != 2'd2);
  assign bus.key_ready  = (KEY_HOLD != 0) ? 1'b1 : (!key_loaded_q || text_fire);
  assign text_fire      = bus.text_valid && bus.text_ready;
  assign key_fire       = bus.key_valid && bus.key_ready;
  assign pop            = bus.out_valid && bus.out_ready;

  assign bus.out_valid  = (cnt_q != 2'd0);
  assign bus.data_out   = head_q;
  assign bus.key_loaded = key_loaded_q;
  assign bus.blk_cnt    = blk_cnt_q;

  always_comb begin
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    if (key_fire) begin
      key_d        = bus.key_in;
      key_loaded_d = 1'b1;
    end else if (KEY_HOLD == 0 && text_fire) begin
      key_loaded_d = 1'b0;
    end

    // Shift-style FIFO: head is always entry 0; a pop to empty leaves head untouched
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({text_fire, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = xored;
        else               tail_d = xored;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = xored;
        end else begin
          head_d = xored;
        end
      end
      default: ;
    endcase

    blk_cnt_d = blk_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= 2'd0;
      blk_cnt_q    <= '0;
    end else begin
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end
endmodule

// File: tb/tb_add_round_key_stream.sv
// Directed bench for add_round_key_stream: one key-hold instance and one consume-key instance.
module tb_add_round_key_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  add_round_key_stream_if #(.NBYTES(16), .BYTEW(8), .CNT_W(8)) ifh ();
  add_round_key_stream_if #(.NBYTES(16), .BYTEW(8), .CNT_W(8)) ifc ();

  add_round_key_stream #(.NBYTES(16), .BYTEW(8), .KEY_HOLD(1), .CNT_W(8)) dut_h (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (ifh.slave)
  );
  add_round_key_stream #(.NBYTES(16), .BYTEW(8), .KEY_HOLD(0), .CNT_W(8)) dut_c (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (ifc.slave)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic [127:0] exp;
  } vec_t;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chkn(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // advance from one falling edge to the next
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t         vt[5];
  logic [127:0] qa, qb, qc, k1, k2, k3, t4, k5;
  logic [127:0] q[$];
  int           sent, got;

  initial begin
    vt[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 128'hFFEEDDCCBBAA99887766554433221100,
              128'hF0E0D0C0B0A090807060504030201000};
    vt[1] = '{{16{8'hFF}}, 128'h0123456789ABCDEFFEDCBA9876543210,
              128'hFEDCBA98765432100123456789ABCDEF};
    vt[2] = '{{16{8'h80}}, {16{8'h7F}}, {16{8'hFF}}};
    vt[3] = '{{16{8'hA5}}, {16{8'hA5}}, 128'h0};
    vt[4] = '{128'h0, 128'hDEADBEEFCAFEBABE0011223344556677,
              128'hDEADBEEFCAFEBABE0011223344556677};

    {ifh.text_in, ifh.text_valid, ifh.key_in, ifh.key_valid, ifh.out_ready} = '0;
    {ifc.text_in, ifc.text_valid, ifc.key_in, ifc.key_valid, ifc.out_ready} = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", ifh.out_valid, 1'b0);
    chk1("rst_key_loaded", ifh.key_loaded, 1'b0);
    chkn("rst_blk_cnt", int'(ifh.blk_cnt), 0);
    chkw("rst_data_out", ifh.data_out, 128'h0);
    chk1("rst_key_ready_hold", ifh.key_ready, 1'b1);
    chk1("rst_key_ready_consume", ifc.key_ready, 1'b1);
    rst_n = 1'b1;
    cyc();

    // no key yet: text is refused until key_loaded rises
    ifh.out_ready  = 1'b1;
    ifh.text_valid = 1'b1;
    ifh.text_in    = vt[0].text;
    #1 chk1("nokey_text_ready", ifh.text_ready, 1'b0);
    cyc();
    chk1("nokey_out_valid", ifh.out_valid, 1'b0);
    ifh.key_valid = 1'b1;
    ifh.key_in    = vt[0].key;
    cyc();
    ifh.key_valid = 1'b0;
    chk1("key_loaded_rise", ifh.key_loaded, 1'b1);
    chk1("text_ready_after_key", ifh.text_ready, 1'b1);
    chk1("no_early_accept", ifh.out_valid, 1'b0);
    cyc();
    ifh.text_valid = 1'b0;
    chk1("first_out_valid", ifh.out_valid, 1'b1);
    chkw("first_data", ifh.data_out, vt[0].exp);
    cyc();
    chkn("first_blk_cnt", int'(ifh.blk_cnt), 1);
    chk1("first_drained", ifh.out_valid, 1'b0);
    chkw("data_held_when_empty", ifh.data_out, vt[0].exp);

    // table of key/text/result vectors
    for (int i = 0; i < 5; i++) begin
      ifh.key_valid = 1'b1;
      ifh.key_in    = vt[i].key;
      cyc();
      ifh.key_valid  = 1'b0;
      ifh.text_valid = 1'b1;
      ifh.text_in    = vt[i].text;
      cyc();
      ifh.text_valid = 1'b0;
      chk1($sformatf("vec%0d_valid", i), ifh.out_valid, 1'b1);
      chkw($sformatf("vec%0d_data", i), ifh.data_out, vt[i].exp);
      cyc();
    end
    chkn("table_blk_cnt", int'(ifh.blk_cnt), 6);

    // backpressure: two buffered, third waits; key is zero so data equals text
    qa = 128'h00112233445566778899AABBCCDDEEFF;
    qb = 128'h13579BDF02468ACE13579BDF02468ACE;
    qc = 128'hFEEDFACE0BADF00D1234567890ABCDEF;
    ifh.out_ready  = 1'b0;
    ifh.text_valid = 1'b1;
    ifh.text_in    = qa;
    cyc();
    ifh.text_in = qb;
    cyc();
    ifh.text_in = qc;
    #1 chk1("full_text_ready", ifh.text_ready, 1'b0);
    chkw("full_head", ifh.data_out, qa);
    cyc();
    chkw("stall_stable", ifh.data_out, qa);
    chk1("stall_valid", ifh.out_valid, 1'b1);
    ifh.out_ready = 1'b1;
    #1 chk1("no_ready_path", ifh.text_ready, 1'b0);
    cyc();
    chkw("order_b", ifh.data_out, qb);
    chk1("space_text_ready", ifh.text_ready, 1'b1);
    cyc();
    ifh.text_valid = 1'b0;
    chkw("order_c", ifh.data_out, qc);
    chk1("order_c_valid", ifh.out_valid, 1'b1);
    cyc();
    chk1("bp_drained", ifh.out_valid, 1'b0);
    chkn("bp_blk_cnt", int'(ifh.blk_cnt), 9);

    // consume-per-block key: same-cycle key load applies only to the next block
    k1 = {16{8'h11}};
    k2 = {16{8'h22}};
    k3 = {16{8'h44}};
    t4 = {16{8'h0F}};
    ifc.out_ready = 1'b1;
    ifc.key_valid = 1'b1;
    ifc.key_in    = k1;
    cyc();
    ifc.key_valid = 1'b0;
    #1 chk1("c_key_ready_busy", ifc.key_ready, 1'b0);
    ifc.text_valid = 1'b1;
    ifc.text_in    = t4;
    ifc.key_valid  = 1'b1;
    ifc.key_in     = k2;
    #1 chk1("c_key_ready_on_fire", ifc.key_ready, 1'b1);
    cyc();
    ifc.key_valid = 1'b0;
    chkw("c_old_key_used", ifc.data_out, {16{8'h1E}});
    chk1("c_key_kept", ifc.key_loaded, 1'b1);
    cyc();
    chkw("c_new_key_used", ifc.data_out, {16{8'h2D}});
    chk1("c_key_consumed", ifc.key_loaded, 1'b0);
    chk1("c_stall_ready", ifc.text_ready, 1'b0);
    cyc();
    chk1("c_stall_out_valid", ifc.out_valid, 1'b0);
    ifc.key_valid = 1'b1;
    ifc.key_in    = k3;
    cyc();
    ifc.key_valid = 1'b0;
    chk1("c_resume_ready", ifc.text_ready, 1'b1);
    cyc();
    ifc.text_valid = 1'b0;
    chkw("c_third_data", ifc.data_out, {16{8'h4B}});

    // asynchronous reset with two blocks buffered
    ifh.out_ready  = 1'b0;
    ifh.text_valid = 1'b1;
    ifh.text_in    = qa;
    cyc();
    ifh.text_in = qb;
    cyc();
    ifh.text_valid = 1'b0;
    chk1("prereset_full", ifh.text_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", ifh.out_valid, 1'b0);
    chk1("arst_key_loaded", ifh.key_loaded, 1'b0);
    chkn("arst_blk_cnt", int'(ifh.blk_cnt), 0);
    chk1("arst_c_key_loaded", ifc.key_loaded, 1'b0);
    @(negedge clk);
    rst_n          = 1'b1;
    ifh.text_valid = 1'b1;
    #1 chk1("post_rst_text_ready", ifh.text_ready, 1'b0);
    cyc();
    chk1("post_rst_out_valid", ifh.out_valid, 1'b0);
    ifh.text_valid = 1'b0;

    // 260 blocks with random consumer stalls; blk_cnt wraps to 4
    k5 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    ifh.key_valid = 1'b1;
    ifh.key_in    = k5;
    cyc();
    ifh.key_valid = 1'b0;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 3000 && got < 260; c++) begin
      ifh.out_ready  = 1'($urandom_range(0, 1));
      ifh.text_valid = (sent < 260);
      ifh.text_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      if (ifh.text_valid && ifh.text_ready) begin
        q.push_back(ifh.text_in ^ k5);
        sent++;
      end
      if (ifh.out_valid && ifh.out_ready) begin
        if (q.size() == 0) chk1("stream_extra_block", ifh.out_valid, 1'b0);
        else begin
          chkw($sformatf("stream_data%0d", got), ifh.data_out, q.pop_front());
          got++;
        end
      end
      cyc();
    end
    ifh.text_valid = 1'b0;
    chkn("stream_received", got, 260);
    chkn("stream_leftover", q.size(), 0);
    chkn("stream_blk_cnt_wrap", int'(ifh.blk_cnt), 4);
    chk1("stream_drained", ifh.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
